// File: rtl/rssi_decision.sv
// RSSI anomaly decision: compares a sign-magnitude sample against its EWMA baseline,
// tracks consecutive anomalies and raises a sticky intrusion alarm.
module rssi_decision (
  input  logic        clk_h,
  input  logic        rst_h,
  input  logic        EnableDecision,
  input  logic [31:0] rssi,
  input  logic [31:0] ewma_rssi,
  input  logic [30:0] threshold,
  input  logic [3:0]  alarm_limit,
  input  logic        clear_alarm,
  output logic        busy,
  output logic        decision_valid,
  output logic        anomaly,
  output logic [30:0] deviation,
  output logic [3:0]  anomaly_count,
  output logic        alarm,
  output logic        overrun
);

  // state   | meaning
  // IDLE    | waiting for EnableDecision, operands free to be latched
  // DIFF    | signed subtract, absolute value, saturate
  // COMPARE | deviation vs threshold -> anomaly candidate
  // REPORT  | publish result, update count/alarm
  typedef enum logic [1:0] {S_IDLE, S_DIFF, S_COMPARE, S_REPORT} state_t;

  state_t      state_q, state_d;
  logic [31:0] rssi_lat_q, rssi_lat_d;
  logic [31:0] ewma_lat_q, ewma_lat_d;
  logic [30:0] diff_q, diff_d;
  logic        cand_q, cand_d;
  logic        valid_q, valid_d;
  logic        anomaly_q, anomaly_d;
  logic [30:0] deviation_q, deviation_d;
  logic [3:0]  count_q, count_d;
  logic        alarm_q, alarm_d;
  logic        overrun_q, overrun_d;

  logic [32:0] rssi_s, ewma_s, sub_s, abs_s;
  logic [30:0] dev_sat;
  logic [3:0]  count_next;

  // Two's complement in 33 bits; the true difference always fits, so modular
  // arithmetic gives the exact signed result. Negative zero maps to 0 naturally.
  assign rssi_s  = rssi_lat_q[31] ? (33'd0 - {2'b00, rssi_lat_q[30:0]}) : {2'b00, rssi_lat_q[30:0]};
  assign ewma_s  = ewma_lat_q[31] ? (33'd0 - {2'b00, ewma_lat_q[30:0]}) : {2'b00, ewma_lat_q[30:0]};
  assign sub_s   = rssi_s - ewma_s;
  assign abs_s   = sub_s[32] ? (33'd0 - sub_s) : sub_s;
  assign dev_sat = (abs_s[32:31] != 2'b00) ? 31'h7FFF_FFFF : abs_s[30:0];

  assign count_next = cand_q ? ((count_q == 4'hF) ? 4'hF : count_q + 4'd1) : 4'd0;

  always_comb begin
    state_d     = state_q;
    rssi_lat_d  = rssi_lat_q;
    ewma_lat_d  = ewma_lat_q;
    diff_d      = diff_q;
    cand_d      = cand_q;
    valid_d     = 1'b0;
    anomaly_d   = anomaly_q;
    deviation_d = deviation_q;
    count_d     = count_q;
    alarm_d     = alarm_q;
    overrun_d   = overrun_q;

    case (state_q)
      S_IDLE: begin
        if (EnableDecision) begin
          rssi_lat_d = rssi;
          ewma_lat_d = ewma_rssi;
          state_d    = S_DIFF;
        end
      end
      S_DIFF: begin
        diff_d  = dev_sat;
        state_d = S_COMPARE;
      end
      S_COMPARE: begin
        cand_d  = (diff_q > threshold);
        state_d = S_REPORT;
      end
      S_REPORT: begin
        valid_d     = 1'b1;
        anomaly_d   = cand_q;
        deviation_d = diff_q;
        count_d     = count_next;
        if ((alarm_limit != 4'd0) && (count_next >= alarm_limit)) alarm_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (EnableDecision && (state_q != S_IDLE)) overrun_d = 1'b1;

    // Clear overrides any set/increment made above in the same cycle.
    if (clear_alarm) begin
      alarm_d   = 1'b0;
      count_d   = 4'd0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk_h or negedge rst_h) begin
    if (!rst_h) begin
      state_q     <= S_IDLE;
      rssi_lat_q  <= '0;
      ewma_lat_q  <= '0;
      diff_q      <= '0;
      cand_q      <= 1'b0;
      valid_q     <= 1'b0;
      anomaly_q   <= 1'b0;
      deviation_q <= '0;
      count_q     <= '0;
      alarm_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rssi_lat_q  <= rssi_lat_d;
      ewma_lat_q  <= ewma_lat_d;
      diff_q      <= diff_d;
      cand_q      <= cand_d;
      valid_q     <= valid_d;
      anomaly_q   <= anomaly_d;
      deviation_q <= deviation_d;
      count_q     <= count_d;
      alarm_q     <= alarm_d;
      overrun_q   <= overrun_d;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign decision_valid = valid_q;
  assign anomaly        = anomaly_q;
  assign deviation      = deviation_q;
  assign anomaly_count  = count_q;
  assign alarm          = alarm_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_rssi_decision.sv
// Self-checking bench for rssi_decision: directed scenarios plus randomized decisions
// checked against an arithmetic reference model.
module tb_rssi_decision;

  logic        clk_h = 1'b0;
  logic        rst_h = 1'b0;
  logic        EnableDecision = 1'b0;
  logic [31:0] rssi = '0;
  logic [31:0] ewma_rssi = '0;
  logic [30:0] threshold = '0;
  logic [3:0]  alarm_limit = '0;
  logic        clear_alarm = 1'b0;
  logic        busy, decision_valid, anomaly, alarm, overrun;
  logic [30:0] deviation;
  logic [3:0]  anomaly_count;

  int total = 0;
  int bad = 0;

  int m_count = 0;
  bit m_alarm = 1'b0;
  bit m_overrun = 1'b0;

  rssi_decision dut (
    .clk_h(clk_h), .rst_h(rst_h), .EnableDecision(EnableDecision),
    .rssi(rssi), .ewma_rssi(ewma_rssi), .threshold(threshold),
    .alarm_limit(alarm_limit), .clear_alarm(clear_alarm),
    .busy(busy), .decision_valid(decision_valid), .anomaly(anomaly),
    .deviation(deviation), .anomaly_count(anomaly_count),
    .alarm(alarm), .overrun(overrun)
  );

  always #5 clk_h = ~clk_h;

  // Drives one decision starting at a negedge; returns at the negedge where
  // decision_valid is seen (cyc = cycles after the pulse, 12 = timed out).
  // dbl: cycle index at which a second, differing pulse is injected (0 = none).
  task automatic decide(input logic [31:0] r, input logic [31:0] e, input logic [30:0] thr,
                        input logic [3:0] lim, input bit clr, input int dbl,
                        output int cyc, output logic [3:0] bseq, output logic [30:0] dev,
                        output logic an, output logic [3:0] cnt, output logic al, output logic ov);
    cyc = 0;
    bseq = '0;
    threshold = thr;
    alarm_limit = lim;
    rssi = r;
    ewma_rssi = e;
    EnableDecision = 1'b1;
    while (cyc < 12) begin
      @(posedge clk_h);
      @(negedge clk_h);
      cyc++;
      EnableDecision = 1'b0;
      clear_alarm = 1'b0;
      if (cyc <= 4) bseq[cyc-1] = busy;
      if (decision_valid) break;
      if (dbl == cyc) begin
        EnableDecision = 1'b1;
        rssi = ~r;
        ewma_rssi = r;
      end
      if (clr && cyc == 3) clear_alarm = 1'b1;
    end
    dev = deviation;
    an = anomaly;
    cnt = anomaly_count;
    al = alarm;
    ov = overrun;
  endtask

  // Reference: signed arithmetic on whole numbers, then the count/alarm rules.
  task automatic model(input logic [31:0] r, input logic [31:0] e, input logic [30:0] thr,
                       input logic [3:0] lim, input bit clr, input int dbl,
                       output logic [30:0] xdev, output logic xan);
    longint a, b, d;
    a = r[31] ? -longint'(r[30:0]) : longint'(r[30:0]);
    b = e[31] ? -longint'(e[30:0]) : longint'(e[30:0]);
    d = a - b;
    if (d < 0) d = -d;
    if (d > 64'sh7FFF_FFFF) d = 64'sh7FFF_FFFF;
    xdev = d[30:0];
    xan = (d > longint'(thr));
    if (dbl == 2 || dbl == 3) m_overrun = 1'b1;
    if (clr) begin
      m_count = 0;
      m_alarm = 1'b0;
      m_overrun = 1'b0;
    end else begin
      m_count = xan ? ((m_count == 15) ? 15 : m_count + 1) : 0;
      if (lim != 0 && m_count >= int'(lim)) m_alarm = 1'b1;
    end
  endtask

  task automatic clear_pulse();
    clear_alarm = 1'b1;
    @(posedge clk_h);
    @(negedge clk_h);
    clear_alarm = 1'b0;
    m_count = 0;
    m_alarm = 1'b0;
    m_overrun = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({busy, decision_valid, anomaly, deviation, anomaly_count, alarm, overrun} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b dv=%b an=%b dev=%0h cnt=%0d al=%b ov=%b want all 0",
               busy, decision_valid, anomaly, deviation, anomaly_count, alarm, overrun);
    end
    @(negedge clk_h);
    rst_h = 1'b1;
    @(negedge clk_h);
  endtask

  task automatic test_basic();
    int cyc; logic [3:0] bs; logic [30:0] dev, xdev; logic an, xan, al, ov; logic [3:0] cnt;
    decide(32'h64, 32'h50, 31'h20, 4'd0, 1'b0, 0, cyc, bs, dev, an, cnt, al, ov);
    model(32'h64, 32'h50, 31'h20, 4'd0, 1'b0, 0, xdev, xan);
    total++;
    if (cyc !== 4) begin bad++; $display("FAIL basic_latency: got %0d want 4", cyc); end
    total++;
    if (bs !== 4'b0111) begin bad++; $display("FAIL basic_busy: got %b want 0111", bs); end
    total++;
    if ({dev, an, cnt} !== {31'h14, 1'b0, 4'd0}) begin
      bad++; $display("FAIL basic_result: got dev=%0h an=%b cnt=%0d want dev=14 an=0 cnt=0", dev, an, cnt);
    end
    @(negedge clk_h);
    total++;
    if ({decision_valid, deviation} !== {1'b0, xdev}) begin
      bad++; $display("FAIL basic_hold: got dv=%b dev=%0h want dv=0 dev=%0h", decision_valid, deviation, xdev);
    end
  endtask

  task automatic test_sign_cross();
    int cyc; logic [3:0] bs; logic [30:0] dev, xdev; logic an, xan, al, ov; logic [3:0] cnt;
    decide(32'h8000_000A, 32'h0000_000A, 31'h13, 4'd0, 1'b0, 0, cyc, bs, dev, an, cnt, al, ov);
    model(32'h8000_000A, 32'h0000_000A, 31'h13, 4'd0, 1'b0, 0, xdev, xan);
    total++;
    if ({dev, an, cnt} !== {31'h14, 1'b1, 4'd1}) begin
      bad++; $display("FAIL sign_anomaly: got dev=%0h an=%b cnt=%0d want dev=14 an=1 cnt=1", dev, an, cnt);
    end
    decide(32'h8000_000A, 32'h0000_000A, 31'h14, 4'd0, 1'b0, 0, cyc, bs, dev, an, cnt, al, ov);
    model(32'h8000_000A, 32'h0000_000A, 31'h14, 4'd0, 1'b0, 0, xdev, xan);
    total++;
    if ({an, cnt} !== {1'b0, 4'd0}) begin
      bad++; $display("FAIL sign_equal_thr: got an=%b cnt=%0d want an=0 cnt=0", an, cnt);
    end
    decide(32'h8000_0000, 32'h0000_0000, 31'h0, 4'd0, 1'b0, 0, cyc, bs, dev, an, cnt, al, ov);
    model(32'h8000_0000, 32'h0000_0000, 31'h0, 4'd0, 1'b0, 0, xdev, xan);
    total++;
    if ({dev, an} !== {31'h0, 1'b0}) begin
      bad++; $display("FAIL neg_zero: got dev=%0h an=%b want dev=0 an=0", dev, an);
    end
  endtask

  task automatic test_alarm();
    int cyc; logic [3:0] bs; logic [30:0] dev, xdev; logic an, xan, al, ov; logic [3:0] cnt;
    for (int i = 1; i <= 3; i++) begin
      decide(32'd100, 32'd0, 31'd10, 4'd3, 1'b0, 0, cyc, bs, dev, an, cnt, al, ov);
      model(32'd100, 32'd0, 31'd10, 4'd3, 1'b0, 0, xdev, xan);
      total++;
      if ({cnt, al} !== {4'(i), (i == 3)}) begin
        bad++; $display("FAIL alarm_step%0d: got cnt=%0d al=%b want cnt=%0d al=%b", i, cnt, al, i, (i == 3));
      end
    end
    decide(32'd5, 32'd4, 31'd10, 4'd3, 1'b0, 0, cyc, bs, dev, an, cnt, al, ov);
    model(32'd5, 32'd4, 31'd10, 4'd3, 1'b0, 0, xdev, xan);
    total++;
    if ({an, cnt, al} !== {1'b0, 4'd0, 1'b1}) begin
      bad++; $display("FAIL alarm_sticky: got an=%b cnt=%0d al=%b want an=0 cnt=0 al=1", an, cnt, al);
    end
    clear_pulse();
    total++;
    if (alarm !== 1'b0) begin bad++; $display("FAIL alarm_clear: got %b want 0", alarm); end
  endtask

  task automatic test_saturation();
    int cyc; logic [3:0] bs; logic [30:0] dev, xdev; logic an, xan, al, ov; logic [3:0] cnt;
    decide(32'h7FFF_FFFF, 32'hFFFF_FFFF, 31'h0, 4'd0, 1'b0, 0, cyc, bs, dev, an, cnt, al, ov);
    model(32'h7FFF_FFFF, 32'hFFFF_FFFF, 31'h0, 4'd0, 1'b0, 0, xdev, xan);
    total++;
    if (dev !== 31'h7FFF_FFFF) begin bad++; $display("FAIL sat_dev: got %0h want 7fffffff", dev); end
    for (int i = 0; i < 20; i++) begin
      decide(32'd9, 32'h8000_0009, 31'd2, 4'd0, 1'b0, 0, cyc, bs, dev, an, cnt, al, ov);
      model(32'd9, 32'h8000_0009, 31'd2, 4'd0, 1'b0, 0, xdev, xan);
    end
    total++;
    if ({cnt, al} !== {4'd15, 1'b0}) begin
      bad++; $display("FAIL sat_count: got cnt=%0d al=%b want cnt=15 al=0", cnt, al);
    end
  endtask

  task automatic test_overrun();
    int cyc, extra; logic [3:0] bs; logic [30:0] dev, xdev; logic an, xan, al, ov; logic [3:0] cnt;
    clear_pulse();
    decide(32'h64, 32'h50, 31'h0, 4'd0, 1'b0, 2, cyc, bs, dev, an, cnt, al, ov);
    model(32'h64, 32'h50, 31'h0, 4'd0, 1'b0, 2, xdev, xan);
    total++;
    if ({cyc, dev, ov} !== {32'd4, 31'h14, 1'b1}) begin
      bad++; $display("FAIL overrun_busy: got cyc=%0d dev=%0h ov=%b want cyc=4 dev=14 ov=1", cyc, dev, ov);
    end
    clear_pulse();
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_clear: got %b want 0", overrun); end
    decide(32'h10, 32'h8000_0010, 31'h0, 4'd0, 1'b0, 3, cyc, bs, dev, an, cnt, al, ov);
    model(32'h10, 32'h8000_0010, 31'h0, 4'd0, 1'b0, 3, xdev, xan);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_h);
      if (decision_valid) extra++;
    end
    total++;
    if ({cyc, dev, ov, extra} !== {32'd4, xdev, 1'b1, 32'd0}) begin
      bad++; $display("FAIL overrun_report: got cyc=%0d dev=%0h ov=%b extra=%0d want cyc=4 dev=%0h ov=1 extra=0",
                      cyc, dev, ov, extra, xdev);
    end
  endtask

  task automatic test_clear_priority();
    int cyc; logic [3:0] bs; logic [30:0] dev, xdev; logic an, xan, al, ov; logic [3:0] cnt;
    decide(32'd50, 32'd0, 31'd1, 4'd2, 1'b0, 0, cyc, bs, dev, an, cnt, al, ov);
    model(32'd50, 32'd0, 31'd1, 4'd2, 1'b0, 0, xdev, xan);
    decide(32'd60, 32'd0, 31'd1, 4'd2, 1'b1, 0, cyc, bs, dev, an, cnt, al, ov);
    model(32'd60, 32'd0, 31'd1, 4'd2, 1'b1, 0, xdev, xan);
    total++;
    if ({cyc, an, dev, cnt, al, ov} !== {32'd4, 1'b1, 31'd60, 4'd0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL clear_priority: got cyc=%0d an=%b dev=%0h cnt=%0d al=%b ov=%b want cyc=4 an=1 dev=3c cnt=0 al=0 ov=0",
                      cyc, an, dev, cnt, al, ov);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, seen; logic [3:0] bs; logic [30:0] dev, xdev; logic an, xan, al, ov; logic [3:0] cnt;
    rssi = 32'd77; ewma_rssi = 32'd1; threshold = 31'd3; alarm_limit = 4'd1;
    EnableDecision = 1'b1;
    @(posedge clk_h);
    @(negedge clk_h);
    EnableDecision = 1'b0;
    rst_h = 1'b0;
    #1;
    total++;
    if ({busy, decision_valid, anomaly, deviation, anomaly_count, alarm, overrun} !== '0) begin
      bad++; $display("FAIL midreset_outputs: got busy=%b dv=%b an=%b dev=%0h cnt=%0d al=%b ov=%b want all 0",
                      busy, decision_valid, anomaly, deviation, anomaly_count, alarm, overrun);
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_h);
      if (decision_valid) seen++;
    end
    rst_h = 1'b1;
    m_count = 0; m_alarm = 1'b0; m_overrun = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_h);
      if (decision_valid) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL midreset_novalid: got %0d pulses want 0", seen); end
    decide(32'd77, 32'd1, 31'd3, 4'd1, 1'b0, 0, cyc, bs, dev, an, cnt, al, ov);
    model(32'd77, 32'd1, 31'd3, 4'd1, 1'b0, 0, xdev, xan);
    total++;
    if ({cyc, dev, an, cnt, al} !== {32'd4, xdev, xan, 4'(m_count), m_alarm}) begin
      bad++; $display("FAIL midreset_after: got cyc=%0d dev=%0h an=%b cnt=%0d al=%b want cyc=4 dev=%0h an=%b cnt=%0d al=%b",
                      cyc, dev, an, cnt, al, xdev, xan, m_count, m_alarm);
    end
  endtask

  task automatic test_random();
    int cyc, dbl, gap; logic [3:0] bs; logic [30:0] dev, xdev; logic an, xan, al, ov; logic [3:0] cnt;
    logic [31:0] r, e; logic [30:0] thr; logic [3:0] lim; bit clr;
    for (int i = 0; i < 60; i++) begin
      r = {$urandom_range(0, 1) == 1, 31'($urandom_range(0, 200))};
      e = {$urandom_range(0, 1) == 1, 31'($urandom_range(0, 200))};
      if ($urandom_range(0, 7) == 0) r = $urandom;
      thr = 31'($urandom_range(0, 150));
      lim = 4'($urandom_range(0, 5));
      clr = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 5))
        0: dbl = 2;
        1: dbl = 3;
        default: dbl = 0;
      endcase
      decide(r, e, thr, lim, clr, dbl, cyc, bs, dev, an, cnt, al, ov);
      model(r, e, thr, lim, clr, dbl, xdev, xan);
      total++;
      if ({cyc, bs, dev, an, cnt, al, ov} !== {32'd4, 4'b0111, xdev, xan, 4'(m_count), m_alarm, m_overrun}) begin
        bad++; $display("FAIL random%0d: got cyc=%0d busy=%b dev=%0h an=%b cnt=%0d al=%b ov=%b want cyc=4 busy=0111 dev=%0h an=%b cnt=%0d al=%b ov=%b",
                        i, cyc, bs, dev, an, cnt, al, ov, xdev, xan, m_count, m_alarm, m_overrun);
      end
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) @(negedge clk_h);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign_cross();
    test_alarm();
    test_saturation();
    test_overrun();
    test_clear_priority();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
